// File: rtl/key_debounce_if.sv
// rtl/key_debounce_if.sv - key input and conditioned key outputs bundle
//
// Ports (interface signals):
//   i_key_n   raw active-low key, driven by the board/bench side
//   o_pressed debounced level, 1 = pressed
//   o_press   one-cycle pulse on accepted press (and repeat pulses)
//   o_release one-cycle pulse on accepted release
// Modports:
//   master - drives the raw key, observes the conditioned outputs
//   slave  - the debouncer: consumes the raw key, drives the outputs
interface key_debounce_if;
  logic i_key_n;
  logic o_pressed;
  logic o_press;
  logic o_release;

  modport master (
    output i_key_n,
    input  o_pressed,
    input  o_press,
    input  o_release
  );

  modport slave (
    input  i_key_n,
    output o_pressed,
    output o_press,
    output o_release
  );
endinterface

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronize, debounce and edge-detect one active-low key
//
// Purpose: conditions a raw push-button into a clean debounced level plus
// one-cycle press/release strobes. o_press drives the core's start strobe.
// Optional macro KEY_REPEAT_EN: while the key is held, o_press re-fires after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
//
// Ports:
//   i_clk   system clock, rising edge
//   i_rst_n asynchronous active-low reset
//   key     key_debounce_if.slave (i_key_n in; o_pressed/o_press/o_release out)
module key_debounce #(
  parameter int CNT_N         = 500000,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  key_debounce_if.slave key
);

  localparam int CW = (CNT_N > 1) ? $clog2(CNT_N) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CNT_N - 1);

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  logic [RW-1:0] rcnt_q, rcnt_d;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HELD = 2'd1
  } state_t;
`endif

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;

  logic sample;
  logic pressed;
  logic accept;

  always_comb begin
    sync1_d   = key.i_key_n;
    sync2_d   = sync1_q;
    sample    = ~sync2_q;
    // The debounced level is carried by the FSM: any non-idle state is pressed.
    pressed   = (state_q != S_IDLE);
    accept    = 1'b0;
    cnt_d     = cnt_q;
    state_d   = state_q;

    if (sample == pressed) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      accept = 1'b1;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    press_d   = accept & sample;
    release_d = accept & ~sample;

`ifdef KEY_REPEAT_EN
    rcnt_d = rcnt_q;
    case (state_q)
      S_IDLE: begin
        rcnt_d = '0;
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        // Release acceptance wins over a coinciding repeat.
        if (accept) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == DLY_MAX) begin
          press_d = 1'b1;
          rcnt_d  = '0;
          state_d = S_REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      S_REPEAT: begin
        if (accept) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == PER_MAX) begin
          press_d = 1'b1;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        rcnt_d  = '0;
      end
    endcase
`else
    case (state_q)
      S_IDLE:  if (accept) state_d = S_HELD;
      S_HELD:  if (accept) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      state_q   <= S_IDLE;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rcnt_q    <= '0;
`endif
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef KEY_REPEAT_EN
      rcnt_q    <= rcnt_d;
`endif
    end
  end

  assign key.o_pressed = pressed;
  assign key.o_press   = press_q;
  assign key.o_release = release_q;

endmodule
